gpio_write_arbiter: RTL and testbench
=====================================

GPIO_WRITE_ARBITER -- requirements
Module: gpio_write_arbiter

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, named CLK and RST as elsewhere in the codebase.
REQ-002 CLK  input  1  rising-edge system clock.
REQ-003 RST  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-004 Req  input  4  per-requester level write request; Req[i] is held from assertion until Ack[i] is sampled high.
REQ-005 ReqAddr  input  8  requested GPIO bit index; requester i uses bits [2i+1:2i].
REQ-006 ReqValue  input  4  requested bit value; requester i uses bit i.
REQ-007 Ack  output  4  one-cycle completion pulse per requester; at most one bit set.
REQ-008 Addr  output  2  GPIO bit index driven to the GPIO register's address input.
REQ-009 Value  output  1  bit value driven to the GPIO register.
REQ-010 CS  output  1  GPIO write strobe, high for exactly one cycle per issued write.
REQ-011 GrantId  output  2  index of the current or most recent winner.
REQ-012 Busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states, IDLE, ISSUE and ACK, encoded in 2 bits; the unused encoding SHALL return to IDLE.
REQ-014 IDLE: when Req is nonzero at a clock edge, the winner SHALL be chosen, its ReqAddr/ReqValue slice SHALL be latched into Addr/Value, GrantId SHALL be updated, and the state SHALL move to ISSUE; when Req is zero, the state SHALL stay in IDLE.
REQ-015 ISSUE: CS SHALL be 1 for this single cycle; the next state SHALL be ACK.
REQ-016 ACK: Ack[GrantId] SHALL be 1 for this single cycle; the next state SHALL be IDLE.
REQ-017 Latency SHALL be fixed: Req sampled at edge E0 gives CS high during E0..E1 and Ack high during E1..E2; the GPIO bit updates at E1; peak throughput is one write per 3 cycles.
REQ-018 Arbitration SHALL be round-robin: the search starts at (LastGrant+1) mod 4 and takes the first set Req bit; LastGrant SHALL update only when a grant is made.
REQ-019 Request changes while Busy SHALL be ignored; Addr/Value SHALL stay stable from the ISSUE cycle through ACK.
REQ-020 A requester whose Req is still high in the IDLE cycle after its Ack SHALL be treated as a new request, subject to round-robin order.
REQ-021 All outputs SHALL be registered; Ack and CS SHALL never be high in the same cycle.
REQ-022 Simultaneous requests from all four requesters SHALL each be served exactly once within 12 cycles.

Reset
REQ-023 On RST=0, the block SHALL immediately force state=IDLE, CS=0, Ack=0, Addr=0, Value=0, GrantId=0, Busy=0 and LastGrant=3, so that requester 0 wins first.
REQ-024 Reset asserted during ISSUE or ACK SHALL abort the transaction with no Ack; a request still held after reset release SHALL be re-arbitrated from IDLE.

Configuration
REQ-025 With the macro GPIO_ARB_SHADOW_EN defined, the block SHALL add output Shadow [3:0], which reset sets to 0.
REQ-026 With GPIO_ARB_SHADOW_EN defined, Shadow[Addr] SHALL update at the edge ending ISSUE.
REQ-027 With GPIO_ARB_SHADOW_EN defined, a granted write whose value equals Shadow[addr] SHALL still pass through ISSUE and ACK with CS held 0, giving the same latency.
REQ-028 Without GPIO_ARB_SHADOW_EN, the block SHALL have no Shadow port, and every granted write SHALL assert CS.

Verification
REQ-029 Reset, then Req=0001, ReqAddr[1:0]=2, ReqValue[0]=1 -> one cycle later CS=1, Addr=2, Value=1; the next cycle Ack=0001; then Busy=0.
REQ-030 Req=1111 held continuously, each requester dropping Req on its Ack -> grant order 0,1,2,3; 4 CS pulses; Ack bits one-hot; total 12 cycles.
REQ-031 After requester 1 is served, Req=0011 -> requester 2 does not participate and 0 wins; pointer-wrap check from LastGrant=3 -> 0 wins.
REQ-032 RST pulsed low during the ISSUE cycle -> CS and Busy drop immediately and no Ack is produced; Req held -> a fresh grant after release.
REQ-033 With GPIO_ARB_SHADOW_EN, write bit 1 = 1 twice -> first write: CS=1 and Shadow=0010; second write: CS=0 and Ack still pulses; without the macro, both writes assert CS.

Source files
------------

// File: rtl/gpio_write_arbiter.sv
// gpio_write_arbiter
//   Round-robin arbiter that lets four requesters share one GPIO register
//   write port. Each granted write takes a fixed three cycles: IDLE
//   (arbitrate and latch), ISSUE (CS strobe) and ACK (one-hot Ack pulse).
//
// Ports
//   CLK       rising-edge system clock
//   RST       asynchronous active-low reset (0 = reset asserted)
//   Req       [3:0] level requests, each held until its Ack is seen
//   ReqAddr   [7:0] requester i drives its GPIO bit index on [2i+1:2i]
//   ReqValue  [3:0] requester i drives its bit value on bit i
//   Ack       [3:0] one-cycle completion pulse, at most one bit set
//   Addr      [1:0] GPIO bit index for the current write
//   Value     bit value for the current write
//   CS        GPIO write strobe, one cycle per issued write
//   GrantId   [1:0] current or most recent winner
//   Busy      high whenever the FSM is not in IDLE
//   Shadow    [3:0] copy of the GPIO bits (only with GPIO_ARB_SHADOW_EN)
//
// Build option
//   GPIO_ARB_SHADOW_EN : adds the Shadow output and suppresses CS for
//   writes that would not change the stored bit. Timing is unchanged.

module gpio_write_arbiter (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Req,
  input  logic [7:0] ReqAddr,
  input  logic [3:0] ReqValue,
  output logic [3:0] Ack,
  output logic [1:0] Addr,
  output logic       Value,
  output logic       CS,
  output logic [1:0] GrantId,
  output logic       Busy
`ifdef GPIO_ARB_SHADOW_EN
  ,
  output logic [3:0] Shadow
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t     state_reg;
  logic [1:0] last_grant_reg;

  // Per-requester views of the packed address bus.
  logic [1:0] addr_slice [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign addr_slice[gi] = ReqAddr[2*gi+1:2*gi];
    end
  endgenerate

  // Round-robin search: first set request starting one past the last winner.
  // The k=4 step wraps back onto the last winner itself, so a lone
  // re-requester is still found.
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_reg + 2'(k);
      if (!win_found && Req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  logic [1:0] win_addr;
  logic       win_value;
  logic       write_needed;

  assign win_addr  = addr_slice[win_id];
  assign win_value = ReqValue[win_id];

`ifdef GPIO_ARB_SHADOW_EN
  // A write that matches the stored bit still runs the full sequence,
  // only the strobe is withheld.
  assign write_needed = (Shadow[win_addr] != win_value);
`else
  assign write_needed = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      last_grant_reg <= 2'd3;   // requester 0 wins the first arbitration
      Ack            <= 4'd0;
      Addr           <= 2'd0;
      Value          <= 1'b0;
      CS             <= 1'b0;
      GrantId        <= 2'd0;
      Busy           <= 1'b0;
`ifdef GPIO_ARB_SHADOW_EN
      Shadow         <= 4'd0;
`endif
    end else begin
      CS  <= 1'b0;
      Ack <= 4'd0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            Addr           <= win_addr;
            Value          <= win_value;
            GrantId        <= win_id;
            last_grant_reg <= win_id;
            CS             <= write_needed;
            Busy           <= 1'b1;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          Ack       <= 4'b0001 << GrantId;
          state_reg <= ACK;
`ifdef GPIO_ARB_SHADOW_EN
          Shadow[Addr] <= Value;
`endif
        end
        ACK: begin
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          Busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// tb_gpio_write_arbiter
//   Randomised and directed bench for gpio_write_arbiter. Each transaction
//   gives every requester a number of services it wants (0..2); the model
//   derives the grant order with a plain round-robin walk over the pending
//   counts and pushes one expected record per write. A monitor pops a record
//   on every Ack pulse and checks the write that preceded it.

module tb_gpio_write_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] Req = 4'd0;
  logic [7:0] ReqAddr = 8'd0;
  logic [3:0] ReqValue = 4'd0;
  logic [3:0] Ack;
  logic [1:0] Addr;
  logic       Value;
  logic       CS;
  logic [1:0] GrantId;
  logic       Busy;
  logic [3:0] Shadow;

  gpio_write_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .Req      (Req),
    .ReqAddr  (ReqAddr),
    .ReqValue (ReqValue),
    .Ack      (Ack),
    .Addr     (Addr),
    .Value    (Value),
    .CS       (CS),
    .GrantId  (GrantId),
    .Busy     (Busy)
`ifdef GPIO_ARB_SHADOW_EN
    ,
    .Shadow   (Shadow)
`endif
  );

`ifndef GPIO_ARB_SHADOW_EN
  assign Shadow = 4'd0;
`endif

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         id;
    logic [1:0] addr;
    logic       val;
    logic       cs;
    logic [3:0] shadow;
  } exp_t;

  exp_t       exp_q[$];
  int         last_m = 3;
  logic [3:0] shadow_m = 4'd0;
  int         cnt_m[4];

  task automatic model_reset();
    last_m   = 3;
    shadow_m = 4'd0;
    exp_q.delete();
  endtask

  // Walk the pending counts in round-robin order, one grant per write.
  task automatic model_push(input logic [7:0] ad, input logic [3:0] vl,
                            output int total);
    int   rem[4];
    exp_t e;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = cnt_m[i];
      total += cnt_m[i];
    end
    for (int n = 0; n < total; n++) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (last_m + k) % 4;
        if (rem[idx] > 0) begin
          rem[idx]--;
          last_m = idx;
          e.id   = idx;
          e.addr = ad[2*idx +: 2];
          e.val  = vl[idx];
`ifdef GPIO_ARB_SHADOW_EN
          e.cs   = (shadow_m[e.addr] != e.val);
`else
          e.cs   = 1'b1;
`endif
          shadow_m[e.addr] = e.val;
`ifdef GPIO_ARB_SHADOW_EN
          e.shadow = shadow_m;
`else
          e.shadow = 4'd0;
`endif
          exp_q.push_back(e);
          break;
        end
      end
    end
  endtask

  // Requesters drop Req once they have seen as many Acks as they wanted.
  // Writes are back to back, so the last Ack lands on negedge 3*total-1.
  task automatic wait_done(input int total);
    int cyc;
    int dc[4];
    cyc = 0;
    for (int i = 0; i < 4; i++) dc[i] = cnt_m[i];
    while (Req != 4'd0 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (Ack[i] && Req[i]) begin
          dc[i]--;
          if (dc[i] <= 0) Req[i] = 1'b0;
        end
      end
    end
    chk("txn_cycles", cyc, 3 * total - 1);
    @(negedge CLK);
    chk("idle_busy", int'(Busy), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("txn: writes=%0d cycles=%0d last_grant=%0d", total, cyc, last_m);
  endtask

  // Called at a negedge; drives the request and waits for completion.
  task automatic do_txn(input int c0, input int c1, input int c2, input int c3,
                        input logic [7:0] ad, input logic [3:0] vl);
    int total;
    cnt_m[0] = c0; cnt_m[1] = c1; cnt_m[2] = c2; cnt_m[3] = c3;
    model_push(ad, vl, total);
    ReqAddr  = ad;
    ReqValue = vl;
    for (int i = 0; i < 4; i++) Req[i] = (cnt_m[i] > 0);
    wait_done(total);
  endtask

  // ---------------- monitor ----------------
  logic       prev_busy = 1'b0;
  logic       prev_cs = 1'b0;
  logic [1:0] prev_addr = 2'd0;
  logic       prev_val = 1'b0;

  always @(negedge CLK) begin
    if (RST) begin
      if (CS && (Ack != 4'd0)) chk("cs_ack_overlap", 1, 0);
      if (CS && !Busy) chk("cs_while_idle", 1, 0);
      if (Ack != 4'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", int'(Ack), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_onehot", int'(Ack), 1 << e.id);
          chk("grant_id", int'(GrantId), e.id);
          chk("addr", int'(Addr), int'(e.addr));
          chk("value", int'(Value), int'(e.val));
          chk("cs_prev_cycle", int'(prev_cs), int'(e.cs));
          chk("busy_prev_cycle", int'(prev_busy), 1);
          chk("addr_stable", int'(prev_addr), int'(e.addr));
          chk("value_stable", int'(prev_val), int'(e.val));
`ifdef GPIO_ARB_SHADOW_EN
          chk("shadow", int'(Shadow), int'(e.shadow));
`endif
          $display("ack: id=%0d addr=%0d val=%0d cs=%0d", e.id, e.addr, e.val, e.cs);
        end
      end
      prev_busy = Busy;
      prev_cs   = CS;
      prev_addr = Addr;
      prev_val  = Value;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_ack", int'(Ack), 0);
    chk("rst_cs", int'(CS), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_grant", int'(GrantId), 0);
    chk("rst_addr", int'(Addr), 0);
    chk("rst_value", int'(Value), 0);
    chk("rst_shadow", int'(Shadow), 0);
    RST = 1'b1;
    @(negedge CLK);

    // Single write from requester 0: bit 2 <= 1.
    do_txn(1, 0, 0, 0, 8'h02, 4'b0001);
    // All four at once: expected order continues round-robin from last.
    do_txn(1, 1, 1, 1, 8'($urandom), 4'($urandom));
    // Requester 1 alone, then 0 and 1 together: 2 is absent so 0 wins.
    do_txn(0, 1, 0, 0, 8'($urandom), 4'($urandom));
    do_txn(1, 1, 0, 0, 8'($urandom), 4'($urandom));
    // Pointer wrap: 3 served, then 0.
    do_txn(0, 0, 0, 1, 8'($urandom), 4'($urandom));
    do_txn(1, 0, 0, 0, 8'($urandom), 4'($urandom));
    // Requester holding Req after its Ack is served again in turn.
    do_txn(0, 0, 2, 1, 8'($urandom), 4'($urandom));
    // Same write to bit 1 twice (second is a no-change write with shadow).
    do_txn(1, 0, 0, 0, 8'h01, 4'b0001);
    do_txn(1, 0, 0, 0, 8'h01, 4'b0001);

    for (int t = 0; t < 25; t++) begin
      int c[4];
      for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 2));
      if (c[0] + c[1] + c[2] + c[3] == 0) c[0] = 1;
      do_txn(c[0], c[1], c[2], c[3], 8'($urandom), 4'($urandom));
    end

    // Reset during ISSUE aborts the write; held request re-arbitrates.
    Req      = 4'b0010;
    ReqAddr  = 8'h0C;
    ReqValue = 4'b0010;
    @(posedge CLK);
    #1;
    chk("pre_abort_cs", int'(CS), 1);
    RST = 1'b0;
    #1;
    chk("abort_cs", int'(CS), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_ack", int'(Ack), 0);
    chk("abort_grant", int'(GrantId), 0);
    model_reset();
    begin
      int total;
      cnt_m[0] = 0; cnt_m[1] = 1; cnt_m[2] = 0; cnt_m[3] = 0;
      model_push(ReqAddr, ReqValue, total);
      @(negedge CLK);
      #2 RST = 1'b1;
      wait_done(total);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
